// File: rtl/bin2therm_pipeline_if.sv
// Code/thermometer bus for bin2therm_pipeline.
// master drives the binary code, slave (the encoder) returns the thermometer code.
interface bin2therm_pipeline_if #(
  parameter int B = 8
);
  logic              valid;
  logic [B-1:0]      bin;
  logic [(1<<B)-1:0] thermo;
  logic              thermo_valid;

  modport master (output valid, bin, input thermo, thermo_valid);
  modport slave  (input valid, bin, output thermo, thermo_valid);
endinterface

// File: rtl/bin2therm_pipeline.sv
// Pipelined binary-to-thermometer encoder, B-2 clocks of latency.
// Structure: input capture, B-4 MSB window stages, 4-bit final stage, output register.
// Optional macro DWA_EN adds a data-weighted-averaging rotation pointer in the output stage.
module bin2therm_pipeline #(
  parameter int B = 8
) (
  input logic           clock,
  input logic           reset,
  bin2therm_pipeline_if.slave bus
);
  localparam int W = 1 << B;
  localparam int N = W - 1;
  localparam int S = B - 4;

  // Mask with the lowest n bits set; n may equal W.
  function automatic logic [W-1:0] low_ones(input logic [B:0] n);
    logic [W:0] t;
    t = ({{W{1'b0}}, 1'b1} << n) - 1'b1;
    return t[W-1:0];
  endfunction

  // Index 0 is the input capture register, 1..S are the MSB stages.
  logic [W-1:0] st_th   [S+1];
  logic [B-1:0] st_code [S+1];
  logic         st_v    [S+1];

  // Input capture: the code is gated with valid so an X on bin never enters.
  always_ff @(posedge clock) begin
    if (reset) begin
      st_th[0]   <= '0;
      st_code[0] <= '0;
      st_v[0]    <= 1'b0;
    end else begin
      st_th[0]   <= '0;
      st_code[0] <= bus.valid ? bus.bin : '0;
      st_v[0]    <= bus.valid;
    end
  end

  for (genvar k = 1; k <= S; k++) begin : g_msb
    localparam int SH = B - k;
    localparam logic [B:0] SIZE = (B+1)'(1) << SH;
    logic [B:0]   base;
    logic [W-1:0] th_n;

    // Window base is the already-resolved high bits; a set bit fills the lower half.
    always_comb begin
      base = {1'b0, (st_code[k-1] >> (SH + 1)) << (SH + 1)};
      th_n = st_th[k-1];
      if (st_code[k-1][SH]) begin
        th_n = st_th[k-1] | (low_ones(base + SIZE) & ~low_ones(base));
      end
    end

    // MSB stage register.
    always_ff @(posedge clock) begin
      if (reset) begin
        st_th[k]   <= '0;
        st_code[k] <= '0;
        st_v[k]    <= 1'b0;
      end else begin
        st_th[k]   <= th_n;
        st_code[k] <= st_code[k-1];
        st_v[k]    <= st_v[k-1];
      end
    end
  end

  logic [B:0]   fbase;
  logic [B:0]   flim;
  logic [W-1:0] fin_th_n;
  logic [W-1:0] fin_th;
  logic         fin_v;

  // Final stage: unary-expand the four low bits inside the resolved 16-element window.
  always_comb begin
    fbase    = {1'b0, st_code[S][B-1:4], 4'b0000};
    flim     = fbase + {{(B-3){1'b0}}, st_code[S][3:0]};
    fin_th_n = st_th[S] | (low_ones(flim) & ~low_ones(fbase));
  end

`ifdef DWA_EN
  logic [B-1:0]   fin_code;
  logic [B-1:0]   ptr;
  logic [B-1:0]   ptr_n;
  logic [2*N-1:0] dbl;
  logic [N-1:0]   rot;
  logic [B:0]     sum;
  logic [B:0]     diff;
  localparam logic [B:0] NB = (B+1)'(N);

  // Final stage register, keeps the code for the pointer update.
  always_ff @(posedge clock) begin
    if (reset) begin
      fin_th   <= '0;
      fin_code <= '0;
      fin_v    <= 1'b0;
    end else begin
      fin_th   <= fin_th_n;
      fin_code <= st_code[S];
      fin_v    <= st_v[S];
    end
  end

  // Rotate the N meaningful elements left by ptr (wrap N-1 -> 0) and advance ptr mod N.
  always_comb begin
    dbl   = {fin_th[N-1:0], fin_th[N-1:0]} << ptr;
    rot   = dbl[2*N-1:N];
    sum   = {1'b0, ptr} + {1'b0, fin_code};
    diff  = sum - NB;
    ptr_n = (sum >= NB) ? diff[B-1:0] : sum[B-1:0];
  end

  // Output register; fin_th[W-1] is structurally 0 so the spare bit stays 0.
  always_ff @(posedge clock) begin
    if (reset) begin
      bus.thermo       <= '0;
      bus.thermo_valid <= 1'b0;
      ptr              <= '0;
    end else begin
      bus.thermo       <= fin_v ? {fin_th[W-1], rot} : '0;
      bus.thermo_valid <= fin_v;
      if (fin_v) ptr <= ptr_n;
    end
  end
`else
  // Final stage register.
  always_ff @(posedge clock) begin
    if (reset) begin
      fin_th <= '0;
      fin_v  <= 1'b0;
    end else begin
      fin_th <= fin_th_n;
      fin_v  <= st_v[S];
    end
  end

  // Output register; invalid slots always show zero.
  always_ff @(posedge clock) begin
    if (reset) begin
      bus.thermo       <= '0;
      bus.thermo_valid <= 1'b0;
    end else begin
      bus.thermo       <= fin_v ? fin_th : '0;
      bus.thermo_valid <= fin_v;
    end
  end
`endif
endmodule

// File: tb/tb_bin2therm_pipeline.sv
// Self-checking bench for bin2therm_pipeline (B=8), with a latency-queue reference model.
module tb_bin2therm_pipeline;
  localparam int B = 8;
  localparam int W = 1 << B;
  localparam int N = W - 1;
  localparam int L = B - 2;
`ifdef DWA_EN
  localparam bit DWA = 1'b1;
`else
  localparam bit DWA = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  bin2therm_pipeline_if #(.B(B)) bus ();
  bin2therm_pipeline #(.B(B)) dut (.clock(clock), .reset(reset), .bus(bus));

  int checks = 0;
  int errors = 0;

  logic [B:0]   q[$];
  int           mptr;
  logic         exp_v;
  logic [W-1:0] exp_t;

  function automatic logic [W-1:0] ones(input int n);
    return (W'(1) << n) - W'(1);
  endfunction

  // Elements (p + t) mod N for t < code are set.
  function automatic logic [W-1:0] therm_of(input int code, input int p);
    logic [W-1:0] r;
    r = '0;
    for (int t = 0; t < code; t++) r = r | (W'(1) << ((p + t) % N));
    return r;
  endfunction

  // Drive one cycle and advance the reference model to the post-edge output.
  task automatic tick(input logic v, input logic [B-1:0] b, input logic r);
    logic [B:0] e;
    reset     = r;
    bus.valid = v;
    bus.bin   = b;
    @(posedge clock);
    if (r) begin
      q.delete();
      for (int i = 0; i < L; i++) q.push_back('0);
      mptr  = 0;
      exp_v = 1'b0;
      exp_t = '0;
    end else begin
      e     = q.pop_front();
      exp_v = e[B];
      exp_t = '0;
      if (e[B]) begin
        exp_t = therm_of(int'(e[B-1:0]), DWA ? mptr : 0);
        if (DWA) mptr = (mptr + int'(e[B-1:0])) % N;
      end
      q.push_back(v ? {1'b1, b} : '0);
    end
    #1;
  endtask

  task automatic test_reset;
    for (int i = 0; i < 3; i++) begin
      tick(1'b1, 8'd77, 1'b1);
      checks++;
      if (bus.thermo_valid !== 1'b0 || bus.thermo !== '0) begin
        errors++;
        $display("FAIL reset: valid=%b thermo=%h, want 0/0", bus.thermo_valid, bus.thermo);
      end
    end
  endtask

  task automatic test_extremes;
    for (int i = 1; i <= 8; i++) begin
      if (i == 1) tick(1'b1, 8'd0, 1'b0);
      else if (i == 2) tick(1'b1, 8'hFF, 1'b0);
      else tick(1'b0, 'x, 1'b0);
      checks++;
      if (bus.thermo_valid !== exp_v || bus.thermo !== exp_t) begin
        errors++;
        $display("FAIL extremes_model: valid=%b thermo=%h, want %b %h", bus.thermo_valid, bus.thermo, exp_v, exp_t);
      end
      if (i == 7) begin
        checks++;
        if (bus.thermo_valid !== 1'b1 || bus.thermo !== '0) begin
          errors++;
          $display("FAIL zero_code: valid=%b thermo=%h, want 1 0", bus.thermo_valid, bus.thermo);
        end
      end
      if (i == 8) begin
        checks++;
        if (bus.thermo_valid !== 1'b1 || bus.thermo !== {1'b0, {N{1'b1}}}) begin
          errors++;
          $display("FAIL full_code: valid=%b thermo=%h, want bits 0..254", bus.thermo_valid, bus.thermo);
        end
      end
    end
  endtask

  task automatic test_back_to_back;
    int c[4] = '{1, 128, 127, 200};
    int k = 0;
    tick(1'b0, 'x, 1'b1);
    for (int i = 1; i <= 11; i++) begin
      if (i <= 4) tick(1'b1, 8'(c[i-1]), 1'b0);
      else tick(1'b0, 'x, 1'b0);
      checks++;
      if (bus.thermo_valid !== exp_v || bus.thermo !== exp_t) begin
        errors++;
        $display("FAIL b2b_model: valid=%b thermo=%h, want %b %h", bus.thermo_valid, bus.thermo, exp_v, exp_t);
      end
      checks++;
      if (bus.thermo_valid !== (i >= 7 && i <= 10)) begin
        errors++;
        $display("FAIL b2b_timing: cycle %0d valid=%b", i, bus.thermo_valid);
      end
      if (bus.thermo_valid === 1'b1 && k < 4) begin
        checks++;
        if ($countones(bus.thermo) != c[k]) begin
          errors++;
          $display("FAIL b2b_popcount: got %0d, want %0d", $countones(bus.thermo), c[k]);
        end
`ifndef DWA_EN
        checks++;
        if (bus.thermo !== ones(c[k])) begin
          errors++;
          $display("FAIL b2b_contiguous: thermo=%h, want %h", bus.thermo, ones(c[k]));
        end
`endif
        k++;
      end
    end
  endtask

  task automatic test_bubbles;
    logic       v[3] = '{1'b1, 1'b0, 1'b1};
    logic [B-1:0] b[3];
    logic [W-1:0] want[3];
    b[0] = 8'd5; b[1] = 'x; b[2] = 8'd9;
    want[0] = W'(32'h1F);
    want[1] = '0;
`ifdef DWA_EN
    want[2] = W'(32'h3FE0);
`else
    want[2] = W'(32'h1FF);
`endif
    tick(1'b0, 'x, 1'b1);
    for (int i = 1; i <= 10; i++) begin
      if (i <= 3) tick(v[i-1], b[i-1], 1'b0);
      else tick(1'b0, 'x, 1'b0);
      checks++;
      if (bus.thermo_valid !== exp_v || bus.thermo !== exp_t) begin
        errors++;
        $display("FAIL bubble_model: valid=%b thermo=%h, want %b %h", bus.thermo_valid, bus.thermo, exp_v, exp_t);
      end
      if (i >= 7 && i <= 9) begin
        checks++;
        if (bus.thermo_valid !== v[i-7] || bus.thermo !== want[i-7]) begin
          errors++;
          $display("FAIL bubble_slot%0d: valid=%b thermo=%h, want %b %h", i - 7, bus.thermo_valid, bus.thermo, v[i-7], want[i-7]);
        end
      end
    end
  endtask

  task automatic test_reset_midstream;
    tick(1'b0, 'x, 1'b1);
    for (int i = 1; i <= 24; i++) begin
      if (i <= 3) tick(1'b1, 8'($urandom_range(1, 254)), 1'b0);
      else if (i == 6) tick(1'b1, 8'd33, 1'b1);
      else if (i == 16) tick(1'b1, 8'd77, 1'b0);
      else tick(1'b0, 'x, 1'b0);
      checks++;
      if (bus.thermo_valid !== (i == 22)) begin
        errors++;
        $display("FAIL midstream_valid: cycle %0d valid=%b", i, bus.thermo_valid);
      end
      checks++;
      if (bus.thermo_valid !== exp_v || bus.thermo !== exp_t) begin
        errors++;
        $display("FAIL midstream_model: valid=%b thermo=%h, want %b %h", bus.thermo_valid, bus.thermo, exp_v, exp_t);
      end
    end
  endtask

  task automatic test_reset_with_valid;
    tick(1'b0, 'x, 1'b1);
    tick(1'b0, 'x, 1'b0);
    tick(1'b1, 8'd50, 1'b1);
    for (int i = 0; i < 9; i++) begin
      tick(1'b0, 'x, 1'b0);
      checks++;
      if (bus.thermo_valid !== 1'b0 || bus.thermo !== '0) begin
        errors++;
        $display("FAIL reset_with_valid: valid=%b thermo=%h, want 0 0", bus.thermo_valid, bus.thermo);
      end
    end
  endtask

  task automatic test_random;
    logic v;
    logic r;
    for (int i = 0; i < 400; i++) begin
      v = ($urandom_range(0, 3) != 0);
      r = ($urandom_range(0, 63) == 0);
      tick(v, v ? 8'($urandom_range(0, 255)) : 'x, r);
      checks++;
      if (bus.thermo_valid !== exp_v || bus.thermo !== exp_t) begin
        errors++;
        $display("FAIL random: valid=%b thermo=%h, want %b %h", bus.thermo_valid, bus.thermo, exp_v, exp_t);
      end
    end
  endtask

`ifdef DWA_EN
  task automatic test_dwa;
    int c[4] = '{200, 100, 0, 10};
    logic [W-1:0] want[4];
    want[0] = ones(200);
    want[1] = (ones(255) ^ ones(200)) | ones(45);
    want[2] = '0;
    want[3] = ones(55) ^ ones(45);
    tick(1'b0, 'x, 1'b1);
    for (int i = 1; i <= 11; i++) begin
      if (i <= 4) tick(1'b1, 8'(c[i-1]), 1'b0);
      else tick(1'b0, 'x, 1'b0);
      if (i >= 7 && i <= 10) begin
        checks++;
        if (bus.thermo_valid !== 1'b1 || bus.thermo !== want[i-7]) begin
          errors++;
          $display("FAIL dwa_out%0d: valid=%b thermo=%h, want 1 %h", i - 7, bus.thermo_valid, bus.thermo, want[i-7]);
        end
      end
    end
  endtask
`endif

  initial begin
    bus.valid = 1'b0;
    bus.bin   = '0;
    test_reset();
    test_extremes();
    test_back_to_back();
    test_bubbles();
    test_reset_midstream();
    test_reset_with_valid();
`ifdef DWA_EN
    test_dwa();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/bin2therm_pipeline.md
Name: bin2therm_pipeline

Overview:
- Pipelined binary-to-thermometer encoder; the inverse of the ADC-side thermometer-to-binary converter.
- Drives unary-weighted DAC / calibration element arrays in the adcv datapath from a binary code.
- One code accepted per clock, fixed latency, valid tracked alongside the data.
- Optional data-weighted-averaging (DWA) rotation for element mismatch shaping.

Parameters:
- B, 8, binary code width; legal range 5..10. Output has 2**B bits, of which N = 2**B-1 are meaningful elements.

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high; clears all state on the clock edge where it is sampled high.
- valid  in  1  input code qualifier, sampled every clock.
- bin  in  B  binary code, sampled with valid.
- thermo  out  2**B  thermometer code, registered.
- thermo_valid  out  1  high when thermo holds a converted code.

Behaviour:
- Reset values: all pipeline data and valid registers are 0; thermo = 0; thermo_valid = 0; DWA pointer = 0.
- Mapping (DWA off): thermo[i] = 1 iff i < bin, for i = 0..2**B-2. thermo[2**B-1] is always 0.
  - bin = 0 gives all zeros; bin = 2**B-1 gives bits 0..2**B-2 set.
- Pipeline structure: B-4 MSB stages, then a 4-bit final stage, then the output register.
  - MSB stage k (k = 0..B-5) resolves bin bit B-1-k.
    - If the bit is set, the stage marks the lower 2**(B-1-k) elements of its current window all-ones and moves the window up.
    - Otherwise it keeps the lower window.
    - Each stage registers the partial thermo vector, the remaining low bits and valid.
  - The final stage expands the 4 remaining bits to 16 unary bits inside the resolved window.
  - The output register then presents the result.
- Latency: exactly B-2 clocks. A code sampled with valid=1 at edge n appears with thermo_valid=1 after edge n+B-2 (6 clocks for B=8).
- Throughput: one code per clock, no stall or backpressure. Valid bubbles propagate unchanged.
- Invalid slots: whenever thermo_valid=0, thermo is forced to 0. Stale data is never shown.
- Simultaneous reset and valid: reset wins; that input code is dropped.
- Reset mid-stream: every code in flight is discarded. thermo_valid stays 0 until B-2 clocks after the first valid following reset deassertion.
- bin is ignored while valid=0, including X values. No X may propagate to thermo.

Optional Feature:
- Macro DWA_EN.
- Defined:
  - A registered pointer ptr, width B, range 0..N-1, reset 0, sits in the output stage.
  - For each valid output, element j (j = 0..N-1) is set iff ((j - ptr) mod N) < bin. The ones are rotated to start at ptr and wrap past N-1 to 0.
  - After that output, ptr <= (ptr + bin) mod N, computed with one conditional subtract of N.
  - ptr holds on invalid slots. thermo[2**B-1] stays 0. Latency is unchanged.
- Undefined: no pointer logic; plain mapping as above.

Test Plan:
- Reset, then bin=0 with valid=1 -> after 6 clocks thermo_valid=1, thermo=0. Bin=255 -> bits 0..254 set, bit 255 = 0.
- Back-to-back bin = 1, 128, 127, 200 -> four consecutive valid outputs with popcounts 1, 128, 127, 200, each a contiguous block from bit 0.
- Valid pattern 1,0,1 with bin = 5, X, 9 -> outputs valid/invalid/valid, with thermo = 0x1F, 0, 0x1FF.
- Reset asserted 3 clocks after three codes are issued -> no thermo_valid pulse for those codes; thermo stays 0. The next code emerges exactly 6 clocks after its input.
- reset=1 and valid=1 on the same edge with bin=50 -> no output for that code.
- DWA_EN, bin = 200 then 100 -> first output sets bits 0..199 and leaves ptr = 200. Second output sets bits 200..254 and 0..44 and leaves ptr = 45. A following bin=0 sets nothing and leaves ptr = 45.
